// File: rtl/data_sram_req.sv
// Data-SRAM request engine: turns one EX load/store into a req/resp bus transaction.
// Optional response watchdog enabled by defining DATA_SRAM_REQ_TIMEOUT_EN.
module data_sram_req #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_we,
  input  logic [1:0]  ex_size,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic        mem_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [3:0]  data_ram_sel,
  output logic [31:0] rdata_out,
  output logic        rdata_valid,
  output logic        stallreq,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;

  logic        is_half, is_word, accept_ok, take_new;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata;
  logic [1:0]  lane_size;

`ifdef DATA_SRAM_REQ_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
`endif

  always_comb begin
    is_half    = (ex_size == 2'b01);
    is_word    = ex_size[1];
    misalign   = ex_valid & ((is_half & ex_addr[0]) | (is_word & (ex_addr[1:0] != 2'b00)));
    accept_ok  = ex_valid & ~misalign;
    lane_sel   = 4'b1111;
    lane_wdata = ex_wdata;
    lane_size  = 2'b10;
    if (!is_word) begin
      if (is_half) begin
        lane_sel   = ex_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{ex_wdata[15:0]}};
        lane_size  = 2'b01;
      end else begin
        lane_sel   = 4'b0001 << ex_addr[1:0];
        lane_wdata = {4{ex_wdata[7:0]}};
        lane_size  = 2'b00;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    size_d   = size_q;
    sel_d    = sel_q;
    we_d     = we_q;
    stallreq = 1'b0;
    take_new = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_ok) begin
          take_new = 1'b1;
          state_d  = S_REQ;
          stallreq = 1'b1;
        end
      end
      S_REQ: begin
        stallreq = 1'b1;
        if (data_addr_ok && data_data_ok) begin
          rdata_d = we_q ? '0 : data_rdata;
          state_d = S_DONE;
        end else if (data_addr_ok) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        stallreq = 1'b1;
        if (data_data_ok) begin
          rdata_d = we_q ? '0 : data_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!mem_stall) begin
          // Accept straight from DONE so back-to-back accesses skip IDLE.
          if (accept_ok) begin
            take_new = 1'b1;
            state_d  = S_REQ;
            stallreq = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take_new) begin
      addr_d  = ex_addr;
      wdata_d = lane_wdata;
      size_d  = lane_size;
      sel_d   = lane_sel;
      we_d    = ex_we;
    end

`ifdef DATA_SRAM_REQ_TIMEOUT_EN
    bus_err_d = 1'b0;
    cnt_d     = cnt_q;
    if (take_new) begin
      cnt_d = '0;
    end else if (state_q == S_REQ || state_q == S_WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
      // A real completion in the expiry cycle wins over the watchdog.
      if (state_d != S_DONE && cnt_q == CNT_LAST) begin
        state_d   = S_DONE;
        rdata_d   = '0;
        sel_d     = '0;
        bus_err_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
    end
  end

`ifdef DATA_SRAM_REQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign data_req     = (state_q == S_REQ);
  assign data_wr      = we_q;
  assign data_size    = size_q;
  assign data_addr    = addr_q;
  assign data_wdata   = wdata_q;
  assign data_ram_sel = sel_q;
  assign rdata_out    = rdata_q;
  assign rdata_valid  = (state_q == S_DONE);

endmodule

// File: tb/tb_data_sram_req.sv
// Scoreboard bench for data_sram_req: directed EX accesses push expected bus requests
// and responses; a negedge monitor pops and compares them as the DUT presents them.
module tb_data_sram_req;

  logic        clk = 1'b0;
  logic        rst, ex_valid, ex_we, mem_stall;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr, ex_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic        data_req, data_wr, rdata_valid, stallreq, misalign, bus_err;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, rdata_out;
  logic [3:0]  data_ram_sel;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  sel;
    logic        berr;
  } resp_t;

  req_t  req_q[$];
  resp_t resp_q[$];
  req_t  cur_req;
  resp_t cur_resp;
  logic  req_prev = 1'b0;
  logic  valid_prev = 1'b0;
  int    checks = 0;
  int    errors = 0;
  int    berr_seen = 0;
  int    berr_exp = 0;
  int    cyc;

  data_sram_req #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_we(ex_we), .ex_size(ex_size),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .mem_stall(mem_stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .data_ram_sel(data_ram_sel), .rdata_out(rdata_out),
    .rdata_valid(rdata_valid), .stallreq(stallreq), .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input req_t r, input resp_t s, input bit has_resp);
    req_q.push_back(r);
    if (has_resp) resp_q.push_back(s);
  endtask

  // Monitor: pops on the rising edge of data_req / rdata_valid, then checks stability.
  always @(negedge clk) begin
    if (rst) begin
      req_prev   = 1'b0;
      valid_prev = 1'b0;
    end else begin
      if (data_req) begin
        if (!req_prev) begin
          if (req_q.size() == 0) begin
            chk("req_unexpected", 1, 0);
          end else begin
            cur_req = req_q.pop_front();
          end
        end
        chk("req_fields", {data_wr, data_size, data_addr, data_wdata}, cur_req);
      end
      if (rdata_valid) begin
        if (!valid_prev) begin
          if (resp_q.size() == 0) begin
            chk("resp_unexpected", 1, 0);
          end else begin
            cur_resp = resp_q.pop_front();
          end
          chk("resp_bus_err", bus_err, cur_resp.berr);
        end
        chk("resp_rdata", rdata_out, cur_resp.rdata);
        chk("resp_sel", data_ram_sel, cur_resp.sel);
      end
      if (bus_err) berr_seen++;
      req_prev   = data_req;
      valid_prev = rdata_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_we = 1'b0; ex_size = 2'b00; ex_addr = '0; ex_wdata = '0;
    mem_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
`ifdef DATA_SRAM_REQ_TIMEOUT_EN
    berr_exp = 1;
`endif
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("reset_outputs", {data_req, data_wr, data_size, data_addr, data_wdata, data_ram_sel,
                          rdata_out, rdata_valid, bus_err, stallreq}, '0);
    data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
    step();
    chk("idle_ignores_data_ok", {rdata_valid, rdata_out}, '0);
    data_data_ok = 1'b0; data_rdata = '0;

    // LW 0x1000, same-cycle addr_ok+data_ok
    ex_valid = 1'b1; ex_we = 1'b0; ex_size = 2'b10; ex_addr = 32'h1000; ex_wdata = '0;
    push('{1'b0, 2'b10, 32'h1000, 32'h0}, '{32'hDEAD_BEEF, 4'b1111, 1'b0}, 1'b1);
    #1 chk("lw_stall_c0", stallreq, 1);
    step();
    ex_valid = 1'b0; data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    #1 chk("lw_stall_c1", stallreq, 1);
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    #1 chk("lw_stall_c2", stallreq, 0);
    chk("lw_valid_c2", rdata_valid, 1);
    step();
    chk("lw_idle_after", rdata_valid, 0);

    // SB 0x1003: stale data_ok in REQ, addr_ok after 2 cycles, data_ok 3 cycles later
    ex_valid = 1'b1; ex_we = 1'b1; ex_size = 2'b00; ex_addr = 32'h1003; ex_wdata = 32'h0000_00A5;
    push('{1'b1, 2'b00, 32'h1003, 32'hA5A5_A5A5}, '{32'h0, 4'b1000, 1'b0}, 1'b1);
    step();
    ex_valid = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h9999_9999;
    step();
    data_data_ok = 1'b0;
    chk("sb_req_ignores_data_ok", data_req, 1);
    step();
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    chk("sb_wait_req_low", {data_req, stallreq, rdata_valid}, 3'b010);
    step();
    step();
    data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    step();
    data_data_ok = 1'b0; data_rdata = '0;
    chk("sb_done", rdata_valid, 1);
    step();

    // LW 0x2000 held by mem_stall, then back-to-back SW
    ex_valid = 1'b1; ex_we = 1'b0; ex_size = 2'b10; ex_addr = 32'h2000; ex_wdata = '0;
    push('{1'b0, 2'b10, 32'h2000, 32'h0}, '{32'h0BAD_F00D, 4'b1111, 1'b0}, 1'b1);
    step();
    ex_valid = 1'b0; data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D;
    mem_stall = 1'b1;
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    repeat (3) step();
    chk("stall_done_held", {rdata_valid, stallreq}, 2'b10);
    step();
    mem_stall = 1'b0;
    ex_valid = 1'b1; ex_we = 1'b1; ex_size = 2'b10; ex_addr = 32'h2004; ex_wdata = 32'h1122_3344;
    push('{1'b1, 2'b10, 32'h2004, 32'h1122_3344}, '{32'h0, 4'b1111, 1'b0}, 1'b1);
    #1 chk("b2b_stall_on_accept", stallreq, 1);
    step();
    ex_valid = 1'b0;
    chk("b2b_req_no_idle", {data_req, rdata_valid}, 2'b10);
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
    step();
    data_data_ok = 1'b0; data_rdata = '0;
    step();

    // Misalignment boundaries, then LH 0x1002
    ex_valid = 1'b1; ex_we = 1'b0; ex_size = 2'b01; ex_addr = 32'h1001; ex_wdata = '0;
    #1 chk("lh_odd_misalign", {misalign, stallreq}, 2'b10);
    step();
    chk("lh_odd_no_req", {data_req, stallreq, rdata_valid}, 3'b000);
    ex_valid = 1'b0;
    #1 chk("misalign_needs_valid", misalign, 0);
    ex_valid = 1'b1; ex_we = 1'b1; ex_size = 2'b10; ex_addr = 32'h1002;
    #1 chk("sw_half_aligned_misalign", misalign, 1);
    ex_size = 2'b11;
    #1 chk("size11_as_word_misalign", misalign, 1);
    ex_size = 2'b00; ex_addr = 32'h1003;
    #1 chk("sb_odd_ok", misalign, 0);
    ex_valid = 1'b0;
    step();
    ex_valid = 1'b1; ex_we = 1'b0; ex_size = 2'b01; ex_addr = 32'h1002; ex_wdata = 32'h0000_BEEF;
    push('{1'b0, 2'b01, 32'h1002, 32'hBEEF_BEEF}, '{32'hCAFE_1234, 4'b1100, 1'b0}, 1'b1);
    step();
    ex_valid = 1'b0; data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hCAFE_1234;
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    step();

`ifdef DATA_SRAM_REQ_TIMEOUT_EN
    // Watchdog: addr_ok never arrives; DONE 9 cycles after the accept cycle
    ex_valid = 1'b1; ex_we = 1'b0; ex_size = 2'b10; ex_addr = 32'h4000; ex_wdata = '0;
    push('{1'b0, 2'b10, 32'h4000, 32'h0}, '{32'h0, 4'b0000, 1'b1}, 1'b1);
    step();
    ex_valid = 1'b0;
    cyc = 1;
    while (!rdata_valid && cyc < 40) begin
      step();
      cyc++;
    end
    chk("timeout_latency", cyc, 9);
    chk("timeout_done", rdata_valid, 1);
    step();
    data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
    step();
    data_data_ok = 1'b0; data_rdata = '0;
    chk("timeout_stale_ignored", {rdata_valid, rdata_out}, '0);
`endif

    // Reset while in WAIT, then a late data_ok
    ex_valid = 1'b1; ex_we = 1'b0; ex_size = 2'b10; ex_addr = 32'h3000; ex_wdata = '0;
    push('{1'b0, 2'b10, 32'h3000, 32'h0}, '{32'h0, 4'b0, 1'b0}, 1'b0);
    step();
    ex_valid = 1'b0; data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; rst = 1'b1;
    chk("wait_stall_before_rst", stallreq, 1);
    step();
    rst = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5555_5555;
    chk("rst_abort_outputs", {data_req, data_wr, data_size, data_addr, data_wdata, data_ram_sel,
                              rdata_out, rdata_valid, bus_err, stallreq}, '0);
    step();
    data_data_ok = 1'b0; data_rdata = '0;
    chk("rst_late_data_ok", {data_req, rdata_valid, rdata_out, data_ram_sel}, '0);
    step();
    chk("rst_stays_idle", rdata_valid, 0);

    repeat (2) step();
    chk("req_queue_empty", req_q.size(), 0);
    chk("resp_queue_empty", resp_q.size(), 0);
    chk("bus_err_pulses", berr_seen, berr_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_sram_req.md
Name: data_sram_req

Overview:
- Data-SRAM request engine between EX and the MEM stage.
- Converts one EX-stage load/store into a request/response transaction on a variable-latency SRAM-like bus.
- Holds the pipeline through `stallreq` until the response arrives, then presents stable read data and byte-lane select to MEM.
- Aligns store data and checks address alignment before any request is issued.

Parameters:
- TIMEOUT_CYCLES, 255, response watchdog limit in cycles; used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  EX holds a memory instruction this cycle
- ex_we  in  1  1 = store, 0 = load
- ex_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- ex_addr  in  32  effective address
- ex_wdata  in  32  raw store operand (rt)
- mem_stall  in  1  downstream MEM/WB stalled (stall[4])
- data_req  out  1  request valid
- data_wr  out  1  request is a write
- data_size  out  2  request size
- data_addr  out  32  request address
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response done / read data valid
- data_rdata  in  32  read data
- data_ram_sel  out  4  byte lanes of the completed access
- rdata_out  out  32  captured read data
- rdata_valid  out  1  completed access held for MEM
- stallreq  out  1  stall request to the stall controller
- misalign  out  1  alignment fault, combinational
- bus_err  out  1  one-cycle timeout pulse

Behaviour:
- Reset state:
  - State goes to IDLE.
  - All outputs are 0: data_req, data_wr, data_size, data_addr, data_wdata, data_ram_sel, rdata_out, rdata_valid, bus_err.
  - A response arriving after reset (data_data_ok in IDLE) is ignored.
- Misalign rule:
  - misalign = ex_valid & ((half & addr[0]) | (word & addr[1:0] != 0)).
  - On misalign, no request is issued, stallreq is not raised and the state is unchanged.
- Lane rules:
  - byte: sel = 1 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - half: sel = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - word: sel = 1111; wdata passed through.
- States:
  - IDLE
    - ex_valid & !misalign: latch addr, size, we, aligned wdata and sel; go to REQ.
    - stallreq = 1 combinationally in this cycle.
  - REQ
    - data_req = 1; all request fields held stable.
    - data_addr_ok & data_data_ok in the same cycle: capture rdata; go to DONE.
    - data_addr_ok alone: go to WAIT.
    - Otherwise stay in REQ.
  - WAIT
    - data_req = 0.
    - On data_data_ok: rdata_out <= data_rdata (loads only; stores leave 0); go to DONE.
  - DONE
    - rdata_valid = 1; stallreq = 0; rdata_out and data_ram_sel held.
    - mem_stall = 1: stay in DONE.
    - mem_stall = 0 with a new valid, aligned ex_valid: latch it and go to REQ. Back-to-back accesses have no IDLE bubble.
    - mem_stall = 0 otherwise: go to IDLE and clear rdata_valid.
- stallreq is 1 in REQ and WAIT, and in IDLE/DONE when a new access is being accepted.
- Minimum latency: 2 cycles from ex_valid to rdata_valid (IDLE→REQ with addr_ok+data_ok, then DONE).
- data_data_ok while in REQ without data_addr_ok is ignored.
- Reset mid-transaction overrides all of the above and aborts the access with no error.

Optional Feature:
- Macro: DATA_SRAM_REQ_TIMEOUT_EN.
- With the macro defined:
  - An 8+ bit counter clears on entry to REQ and increments in REQ and WAIT.
  - When the count reaches TIMEOUT_CYCLES: go to DONE with rdata_out = 0 and data_ram_sel = 0, and pulse bus_err for 1 cycle.
  - A later stale data_data_ok is ignored.
- Without the macro:
  - No counter is built; bus_err is tied to 0.
  - The engine waits in REQ/WAIT indefinitely.

Test Plan:
- LW, addr 0x1000, addr_ok and data_ok in the same cycle as data_req, rdata 0xDEADBEEF → rdata_valid at cycle 2, rdata_out 0xDEADBEEF, sel 1111, stallreq high exactly 2 cycles.
- SB, addr 0x1003, wdata 0x000000A5, addr_ok after 2 cycles, data_ok 3 cycles later → data_wdata 0xA5A5A5A5, sel 1000, data_wr 1, request fields stable throughout REQ.
- LH, addr 0x1001 → misalign 1, data_req never asserted, stallreq 0; LH, addr 0x1002 → sel 1100.
- Completed load with mem_stall held 4 cycles → DONE persists and rdata_out is stable; back-to-back SW issued on release → REQ the next cycle with no IDLE.
- rst asserted in WAIT, then a late data_data_ok → state IDLE, outputs 0, rdata_valid stays 0.
- With DATA_SRAM_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, data_addr_ok never asserted → bus_err pulses once after 8 cycles, rdata_valid 1, rdata_out 0.
